// File: rtl/motion_detect_sched.sv
// Input sequencer for motion_detect_top: routes the background frame to bg_gs, then sends the current frame to frame_gs/frame_hl in lock-step.
// Optional macro MODET_SCHED_STALL_CNT_EN adds a saturating downstream-stall cycle counter on stall_cycles.
module motion_detect_sched #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        in_empty,
    input  logic [23:0] in_dout,
    output logic        in_rd_en,
    input  logic        bg_gs_full,
    output logic        bg_gs_we,
    output logic [23:0] bg_gs_din,
    input  logic        frame_gs_full,
    output logic        frame_gs_we,
    output logic [23:0] frame_gs_din,
    input  logic        frame_hl_full,
    output logic        frame_hl_we,
    output logic [23:0] frame_hl_din,
    input  logic        hl_out_empty,
    input  logic        hl_out_re,
    output logic        busy,
    output logic        done
`ifdef MODET_SCHED_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, BG, FRAME, DRAIN} state_t;

    state_t          state_q;
    logic [CW-1:0]   in_cnt_q;
    logic [CW-1:0]   out_cnt_q;
    logic            done_q;

    logic bg_xfer;
    logic fr_xfer;
    logic xfer;
    logic pop;
    logic start_acc;

    always_comb begin
        bg_xfer   = (state_q == BG) && !in_empty && !bg_gs_full;
        fr_xfer   = (state_q == FRAME) && !in_empty && !frame_gs_full && !frame_hl_full;
        xfer      = bg_xfer || fr_xfer;
        pop       = hl_out_re && !hl_out_empty && (state_q != IDLE);
        // A start landing in the done cycle is dropped; the pass just finished.
        start_acc = (state_q == IDLE) && start && !done_q;
    end

    assign in_rd_en     = xfer;
    assign bg_gs_we     = bg_xfer;
    assign frame_gs_we  = fr_xfer;
    assign frame_hl_we  = fr_xfer;
    assign bg_gs_din    = (state_q == BG)    ? in_dout : 24'h0;
    assign frame_gs_din = (state_q == FRAME) ? in_dout : 24'h0;
    assign frame_hl_din = (state_q == FRAME) ? in_dout : 24'h0;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

    // NOTE: state registers use non-blocking assignments and an async reset, so every read sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start_acc) begin
                    state_q   <= BG;
                    in_cnt_q  <= '0;
                    out_cnt_q <= '0;
                end
            end else begin
                if (xfer) begin
                    if (in_cnt_q == LAST) begin
                        in_cnt_q <= '0;
                        state_q  <= (state_q == BG) ? FRAME : DRAIN;
                    end else begin
                        in_cnt_q <= in_cnt_q + 1'b1;
                    end
                end
                // Result completion wins over any phase advance in the same cycle.
                if (pop) begin
                    out_cnt_q <= out_cnt_q + 1'b1;
                    if (out_cnt_q == LAST) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            end
        end
    end

`ifdef MODET_SCHED_STALL_CNT_EN
    logic [31:0] stall_q;
    logic        stall_hit;

    assign stall_hit = ((state_q == BG) || (state_q == FRAME)) && !in_empty && !xfer;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (stall_hit && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_motion_detect_sched.sv
// Scoreboard bench for motion_detect_sched (WIDTH=4, HEIGHT=2): stimulus queues expected pixels/done, a negedge monitor pops and compares.
module tb_motion_detect_sched;

    localparam int N = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        in_empty;
    logic [23:0] in_dout;
    logic        in_rd_en;
    logic        bg_gs_full;
    logic        bg_gs_we;
    logic [23:0] bg_gs_din;
    logic        frame_gs_full;
    logic        frame_gs_we;
    logic [23:0] frame_gs_din;
    logic        frame_hl_full;
    logic        frame_hl_we;
    logic [23:0] frame_hl_din;
    logic        hl_out_empty;
    logic        hl_out_re;
    logic        busy;
    logic        done;
`ifdef MODET_SCHED_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    motion_detect_sched #(.WIDTH(4), .HEIGHT(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_empty     (in_empty),
        .in_dout      (in_dout),
        .in_rd_en     (in_rd_en),
        .bg_gs_full   (bg_gs_full),
        .bg_gs_we     (bg_gs_we),
        .bg_gs_din    (bg_gs_din),
        .frame_gs_full(frame_gs_full),
        .frame_gs_we  (frame_gs_we),
        .frame_gs_din (frame_gs_din),
        .frame_hl_full(frame_hl_full),
        .frame_hl_we  (frame_hl_we),
        .frame_hl_din (frame_hl_din),
        .hl_out_empty (hl_out_empty),
        .hl_out_re    (hl_out_re),
        .busy         (busy),
        .done         (done)
`ifdef MODET_SCHED_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    logic [23:0] src_q[$];
    logic [23:0] exp_bg[$];
    logic [23:0] exp_fr[$];
    int          exp_done_cyc[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int results = 0;
    int pass_pops = 0;
    int bg_seen = 0;
    int fr_seen = 0;
    int last_bg_cyc = 0;
    int first_fr_cyc = 0;
    bit exp_busy = 1'b0;
    bit starve = 1'b0;
    bit sink_en = 1'b1;

    bit s_rd = 1'b0;
    bit s_fr = 1'b0;
    bit s_pop = 1'b0;
    bit s_start_acc = 1'b0;
    bit s_busy_clr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void refresh();
        in_empty     = starve || (src_q.size() == 0);
        in_dout      = (src_q.size() > 0) ? src_q[0] : 24'h0;
        hl_out_empty = (results == 0);
        hl_out_re    = sink_en && (results > 0);
    endfunction

    // Monitor: everything seen here is what the next rising edge commits.
    always @(negedge clock) begin : mon
        logic [23:0] e;
        bit          done_now;
        cyc++;
        done_now = (exp_done_cyc.size() > 0) && (exp_done_cyc[0] == cyc);
        if (done || done_now) begin
            check("done", 32'(done), 32'(done_now));
            if (done_now) void'(exp_done_cyc.pop_front());
        end
        check("busy", 32'(busy), 32'(exp_busy));
        check("rd_en", 32'(in_rd_en), 32'(bg_gs_we | frame_gs_we));
        check("fr_lockstep", 32'(frame_hl_we), 32'(frame_gs_we));
        if (in_empty) check("rd_while_empty", 32'(in_rd_en), 32'd0);
        if (frame_gs_full || frame_hl_full) check("fr_we_full", 32'(frame_gs_we | frame_hl_we), 32'd0);
        if (bg_gs_we) begin
            if (exp_bg.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL bg_extra: got write %h, expected none", bg_gs_din);
            end else begin
                e = exp_bg.pop_front();
                check("bg_din", 32'(bg_gs_din), 32'(e));
                check("fr_din_in_bg", 32'(frame_gs_din | frame_hl_din), 32'd0);
            end
            bg_seen++;
            last_bg_cyc = cyc;
        end
        if (frame_gs_we) begin
            if (exp_fr.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL fr_extra: got write %h, expected none", frame_gs_din);
            end else begin
                e = exp_fr.pop_front();
                check("fr_gs_din", 32'(frame_gs_din), 32'(e));
                check("fr_hl_din", 32'(frame_hl_din), 32'(e));
                check("bg_din_in_fr", 32'(bg_gs_din), 32'd0);
            end
            if (fr_seen == 0) first_fr_cyc = cyc;
            fr_seen++;
        end
        s_rd        = in_rd_en;
        s_fr        = frame_hl_we;
        s_pop       = hl_out_re && !hl_out_empty;
        s_start_acc = start && !reset && !exp_busy && !done_now;
        s_busy_clr  = 1'b0;
        if (s_pop && exp_busy) begin
            pass_pops++;
            if (pass_pops == N) begin
                exp_done_cyc.push_back(cyc + 1);
                s_busy_clr = 1'b1;
            end
        end
    end

    // Source and result FIFO models advance just after each rising edge.
    always @(posedge clock) begin
        #1;
        if (s_rd && (src_q.size() > 0)) void'(src_q.pop_front());
        if (s_fr) results++;
        if (s_pop && (results > 0)) results--;
        if (s_busy_clr) exp_busy = 1'b0;
        if (s_start_acc) begin
            exp_busy  = 1'b1;
            pass_pops = 0;
        end
        refresh();
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic load(input logic [23:0] base);
        for (int i = 0; i < 2 * N; i++) begin
            src_q.push_back(base + 24'(i));
            if (i < N) exp_bg.push_back(base + 24'(i));
            else       exp_fr.push_back(base + 24'(i));
        end
        bg_seen = 0;
        fr_seen = 0;
        refresh();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // sel 0: pass pops, 1: frame writes, 2: bg writes
    task automatic wait_until(input int sel, input int target, input string what);
        int k;
        k = 0;
        forever begin
            @(negedge clock);
            #1;
            if ((sel == 0 && pass_pops >= target) || (sel == 1 && fr_seen >= target) ||
                (sel == 2 && bg_seen >= target)) break;
            k++;
            if (k > 300) begin
                n_vec++;
                n_err++;
                $display("FAIL timeout_%s: got no event in 300 cycles, expected one", what);
                break;
            end
        end
    endtask

    task automatic end_of_pass(input string tag);
        repeat (3) tick();
        check({tag, "_bg_left"}, 32'(exp_bg.size()), 32'd0);
        check({tag, "_fr_left"}, 32'(exp_fr.size()), 32'd0);
        check({tag, "_src_left"}, 32'(src_q.size()), 32'd0);
        check({tag, "_done_left"}, 32'(exp_done_cyc.size()), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bg_gs_full = 1'b0;
        frame_gs_full = 1'b0;
        frame_hl_full = 1'b0;
        refresh();
        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd", 32'(in_rd_en), 32'd0);
        check("rst_we", 32'({bg_gs_we, frame_gs_we, frame_hl_we}), 32'd0);
        check("rst_din", 32'(bg_gs_din | frame_gs_din | frame_hl_din), 32'd0);
        reset = 1'b0;
        tick();

        // Basic pass plus phase boundary timing.
        load(24'h000001);
        pulse_start();
        wait_until(0, N, "basic");
        end_of_pass("basic");
        check("phase_gap", 32'(first_fr_cyc - last_bg_cyc), 32'd1);

        // Split backpressure: frame_hl_full for 5 cycles inside FRAME.
        load(24'h000100);
        pulse_start();
        wait_until(1, 2, "fr2");
        tick();
        frame_hl_full = 1'b1;
        repeat (5) tick();
        frame_hl_full = 1'b0;
        wait_until(0, N, "split");
        end_of_pass("split");
`ifdef MODET_SCHED_STALL_CNT_EN
        check("stall_split", stall_cycles, 32'd5);
`endif

        // Source starvation mid-BG.
        load(24'h000200);
        pulse_start();
        wait_until(2, 3, "bg3");
        tick();
        starve = 1'b1;
        refresh();
        repeat (10) tick();
        starve = 1'b0;
        refresh();
        wait_until(0, N, "starve");
        end_of_pass("starve");
`ifdef MODET_SCHED_STALL_CNT_EN
        check("stall_starve", stall_cycles, 32'd0);
`endif

        // Start ignored in BG and in the done cycle.
        load(24'h000300);
        pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_until(0, N, "ign");
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        end_of_pass("ign");

        // Second full pass after the ignored starts.
        load(24'h000400);
        pulse_start();
        wait_until(0, N, "second");
        end_of_pass("second");

        // Reset mid-FRAME after 3 frame pixels.
        load(24'h000500);
        pulse_start();
        wait_until(1, 3, "fr3");
        tick();
        reset = 1'b1;
        exp_busy = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd", 32'(in_rd_en), 32'd0);
        check("mid_rst_we", 32'({bg_gs_we, frame_gs_we, frame_hl_we}), 32'd0);
        check("mid_rst_din", 32'(bg_gs_din | frame_gs_din | frame_hl_din), 32'd0);
        src_q.delete();
        exp_bg.delete();
        exp_fr.delete();
        exp_done_cyc.delete();
        results = 0;
        pass_pops = 0;
        refresh();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        load(24'h000600);
        pulse_start();
        wait_until(0, N, "after_rst");
        end_of_pass("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected summary");
        $fatal(1);
    end

endmodule
